// File: rtl/iterative_muldiv_if.sv
// Request/result bundle between a requester and the iterative multiply/divide unit.
// The master drives the operation and operands. The slave returns status and the HI/LO result words.
interface iterative_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/iterative_muldiv.sv
// Iterative one-bit-per-clock multiply/divide: shift-add for MUL(U), restoring shift-subtract for DIV(U).
// Optional MULDIV_ZERO_FAST_EN: trivial zero-operand / divide-by-zero cases skip straight to FIX.
module iterative_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  iterative_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

`ifdef MULDIV_ZERO_FAST_EN
  localparam bit ZeroFast = 1'b1;
`else
  localparam bit ZeroFast = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX} stateType;

  stateType         stateReg, stateNext;
  logic [CW-1:0]    countReg;
  logic             isDivReg;
  logic             negLoReg, negHiReg, zeroDivReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] operandReg;  // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0] hiReg;       // partial-product high word, or running remainder
  logic [WIDTH-1:0] loReg;       // multiplier shifting out / quotient shifting in
  logic             doneReg, divByZeroReg;
  logic [WIDTH-1:0] resultLoReg, resultHiReg;

  // Operand conditioning at accept time
  logic             opSigned, opDiv, aNeg, bNeg, aZero, bZero, fastZero;
  logic [WIDTH-1:0] absA, absB;

  always_comb begin
    opSigned = bus.op[0];
    opDiv    = bus.op[1];
    aNeg     = opSigned & bus.a[WIDTH-1];
    bNeg     = opSigned & bus.b[WIDTH-1];
    absA     = aNeg ? -bus.a : bus.a;
    absB     = bNeg ? -bus.b : bus.b;
    aZero    = (bus.a == '0);
    bZero    = (bus.b == '0);
    fastZero = opDiv ? bZero : (aZero | bZero);
  end

  // One iteration step of each algorithm
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic             qBit;

  always_comb begin
    mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, operandReg} : '0);
    divShift = {hiReg, loReg[WIDTH-1]};
    divDiff  = divShift - {1'b0, operandReg};
    qBit     = ~divDiff[WIDTH];
  end

  // Sign correction and divide-by-zero override applied in FIX
  logic [2*WIDTH-1:0] product, productFixed;
  logic [WIDTH-1:0]   fixLo, fixHi;

  always_comb begin
    product      = {hiReg, loReg};
    productFixed = negLoReg ? -product : product;
    fixLo        = productFixed[WIDTH-1:0];
    fixHi        = productFixed[2*WIDTH-1:WIDTH];
    if (isDivReg) begin
      fixLo = negLoReg ? -loReg : loReg;
      fixHi = negHiReg ? -hiReg : hiReg;
      if (zeroDivReg) begin
        fixLo = '1;
        fixHi = aReg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (bus.start) stateNext = (ZeroFast && fastZero) ? FIX : CALC;
      CALC: if (countReg == LastCount) stateNext = FIX;
      FIX:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      countReg     <= '0;
      isDivReg     <= 1'b0;
      negLoReg     <= 1'b0;
      negHiReg     <= 1'b0;
      zeroDivReg   <= 1'b0;
      aReg         <= '0;
      operandReg   <= '0;
      hiReg        <= '0;
      loReg        <= '0;
      doneReg      <= 1'b0;
      divByZeroReg <= 1'b0;
      resultLoReg  <= '0;
      resultHiReg  <= '0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: if (bus.start) begin
          isDivReg     <= opDiv;
          aReg         <= bus.a;
          countReg     <= '0;
          hiReg        <= '0;
          divByZeroReg <= 1'b0;
          zeroDivReg   <= opDiv & bZero;
          if (opDiv) begin
            operandReg <= absB;
            loReg      <= absA;
            negLoReg   <= aNeg ^ bNeg;
            negHiReg   <= aNeg;
          end else begin
            operandReg <= absA;
            // A skipped multiply must still present a zero product in FIX
            loReg      <= (ZeroFast && fastZero) ? '0 : absB;
            negLoReg   <= (aNeg ^ bNeg) & ~aZero & ~bZero;
            negHiReg   <= (aNeg ^ bNeg) & ~aZero & ~bZero;
          end
        end
        CALC: begin
          countReg <= countReg + 1'b1;
          if (isDivReg) begin
            hiReg <= qBit ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            loReg <= {loReg[WIDTH-2:0], qBit};
          end else begin
            hiReg <= mulSum[WIDTH:1];
            loReg <= {mulSum[0], loReg[WIDTH-1:1]};
          end
        end
        FIX: begin
          resultLoReg  <= fixLo;
          resultHiReg  <= fixHi;
          divByZeroReg <= zeroDivReg;
          doneReg      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (stateReg != IDLE);
  assign bus.done        = doneReg;
  assign bus.result_lo   = resultLoReg;
  assign bus.result_hi   = resultHiReg;
  assign bus.div_by_zero = divByZeroReg;

endmodule
